mul_float: RTL and testbench
============================

MUL_FLOAT -- requirements
Module: mul_float

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous assert, active-high.
REQ-004 in_valid  input  1  a/b are sampled on this cycle when high.
REQ-005 a  input  32  operand A, binary32 (sign 31, exponent 30:23, fraction 22:0).
REQ-006 b  input  32  operand B, binary32.
REQ-007 result  output  32  registered product a*b, binary32.
REQ-008 out_valid  output  1  high for exactly the one cycle in which result holds a new product.

Function
REQ-009 Latency SHALL be exactly 1 cycle.
  - When in_valid=1 at rising edge N, result and out_valid=1 SHALL be updated at edge N.
  - They SHALL be visible until edge N+1.
REQ-010 When in_valid=0 at an edge, out_valid SHALL go 0 and result SHALL hold its previous value.
REQ-011 Back-to-back in_valid SHALL be accepted every cycle with no stalls; there is no backpressure.
REQ-012 Sign SHALL be sign(a) XOR sign(b) for zero, infinity and finite results.
REQ-013 NaN rule: if either operand is NaN (exp=FF, frac!=0), result SHALL be canonical quiet NaN 32'h7FC00000.
REQ-014 Invalid rule: Inf times zero (either order, any signs) SHALL give 32'h7FC00000.
REQ-015 Infinity rule: Inf times finite nonzero, or Inf times Inf, SHALL give signed infinity {s,8'hFF,23'h0}.
REQ-016 Zero rule: zero times finite SHALL give signed zero {s,31'h0}.
REQ-017 Subnormal operands (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero on input).
REQ-018 Normal path arithmetic:
  - Multiply the 24x24 significands with the hidden 1 into a 48-bit product.
  - Compute the exponent as ea+eb-127 in at least 10 bits, signed.
  - If product bit 47 is set, shift right by 1 and increment the exponent.
REQ-019 Rounding SHALL be round-to-nearest-even, using guard, round and sticky bits from the discarded product bits.
REQ-020 A mantissa carry-out from rounding SHALL renormalise the result and increment the exponent.
REQ-021 Overflow: a final biased exponent >= 255 SHALL give signed infinity.
REQ-022 Underflow: a final biased exponent <= 0 SHALL give signed zero; no subnormal outputs are produced.
REQ-023 The block SHALL raise no exception flags.

Reset
REQ-024 While rst=1, result SHALL be 32'h00000000 and out_valid SHALL be 0, immediately and independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight product.
REQ-026 The first in_valid sampled after rst deasserts SHALL produce a normal result one cycle later.

Structure
REQ-027 A shared package SHALL hold:
  - binary32 field widths and the bias constant 127;
  - QNAN = 32'h7FC00000, exponent all-ones 8'hFF, field-extraction constants.
REQ-028 The design SHALL be a combinational core plus one output register stage.
  - The combinational core is the sub-module mul_float_core: a, b -> product, with special-case decode, multiply, normalise, round.
  - mul_float holds only the registers and valid tracking.

Verification
REQ-029 40200000 x 40400000 (2.5 x 3.0) with in_valid=1 -> next edge result=40F00000, out_valid=1.
REQ-030 Sign and scale products:
  - BFC00000 x 40800000 -> C0C00000.
  - 3E800000 x 3F000000 -> 3E000000.
  - 00000000 x 40A00000 -> 00000000.
REQ-031 Special operands:
  - 7F800000 x 40000000 -> 7F800000.
  - 7F800000 x 00000000 -> 7FC00000.
  - 7FC00000 x 3F800000 -> 7FC00000.
REQ-032 Rounding and range limits:
  - 3F800001 x 3F800001 -> 3F800002 (RNE tie-free round).
  - 7F7FFFFF x 40000000 -> 7F800000 (overflow).
  - 00800000 x 00800000 -> 00000000 (underflow flush).
REQ-033 Streaming 7 back-to-back valid inputs -> 7 consecutive out_valid pulses with results in order.
  - Then in_valid=0 -> out_valid=0 and result held.
REQ-034 Assert rst mid-stream -> result=0 and out_valid=0 immediately, without waiting for a clock edge.
  - After release, the next valid input is processed correctly.

Source files
------------

// File: rtl/mul_float_pkg.sv
// Shared binary32 field layout and constants for the mul_float slice.
package mul_float_pkg;

  localparam int WORD_W = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int BIAS   = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  EXP_ONES = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/mul_float_core.sv
// Combinational binary32 multiply: special-case decode, 24x24 multiply,
// normalise, round-to-nearest-even, flush-to-zero on inputs and outputs.
module mul_float_core
  import mul_float_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] product
);

  fp32_t op_a;
  fp32_t op_b;

  logic                sign_r;
  logic                a_nan, a_inf, a_zero;
  logic                b_nan, b_inf, b_zero;
  logic [SIG_W-1:0]    sig_a, sig_b;
  logic [PROD_W-1:0]   prod_full;
  logic signed [9:0]   exp_raw, exp_norm, exp_fin;
  logic [FRAC_W-1:0]   frac_pre;
  logic                guard, round_bit, sticky, round_up;
  logic [FRAC_W:0]     frac_rnd;

  assign op_a = a;
  assign op_b = b;

  // Subnormals fall into the zero class, which gives flush-to-zero on input.
  assign a_nan  = (op_a.exp == EXP_ONES) && (op_a.frac != '0);
  assign a_inf  = (op_a.exp == EXP_ONES) && (op_a.frac == '0);
  assign a_zero = (op_a.exp == '0);
  assign b_nan  = (op_b.exp == EXP_ONES) && (op_b.frac != '0);
  assign b_inf  = (op_b.exp == EXP_ONES) && (op_b.frac == '0);
  assign b_zero = (op_b.exp == '0);

  assign sign_r = op_a.sign ^ op_b.sign;
  assign sig_a  = {1'b1, op_a.frac};
  assign sig_b  = {1'b1, op_b.frac};

  always_comb begin
    prod_full = PROD_W'(sig_a) * PROD_W'(sig_b);
    exp_raw   = {2'b00, op_a.exp} + {2'b00, op_b.exp} - 10'(BIAS);

    if (prod_full[PROD_W-1]) begin
      frac_pre  = prod_full[46:24];
      guard     = prod_full[23];
      round_bit = prod_full[22];
      sticky    = |prod_full[21:0];
      exp_norm  = exp_raw + 10'sd1;
    end else begin
      frac_pre  = prod_full[45:23];
      guard     = prod_full[22];
      round_bit = prod_full[21];
      sticky    = |prod_full[20:0];
      exp_norm  = exp_raw;
    end

    round_up = guard & (round_bit | sticky | frac_pre[0]);
    frac_rnd = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, round_up};
    // A carry out leaves the fraction field at zero; only the exponent moves.
    exp_fin  = exp_norm + {9'd0, frac_rnd[FRAC_W]};

    if (a_nan || b_nan) begin
      product = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      product = QNAN;
    end else if (a_inf || b_inf) begin
      product = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      product = {sign_r, {(WORD_W-1){1'b0}}};
    end else if (exp_fin >= 10'sd255) begin
      product = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (exp_fin <= 10'sd0) begin
      product = {sign_r, {(WORD_W-1){1'b0}}};
    end else begin
      product = {sign_r, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/mul_float.sv
// binary32 multiplier: combinational core plus one output register stage,
// one-cycle latency, accepts a new operand pair every cycle.
module mul_float
  import mul_float_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result,
  output logic              out_valid
);

  logic [WORD_W-1:0] product_c;

  mul_float_core u_core (
    .a       (a),
    .b       (b),
    .product (product_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= product_c;
      end
    end
  end

endmodule

// File: tb/tb_mul_float.sv
// Scoreboard bench for mul_float: directed and random operands against a
// real-arithmetic reference model.
module tb_mul_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  mul_float dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every presented product must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=%h required=none", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [31:0] x);
    return real'(8388608 + int'(x[22:0])) * pow2(int'(x[30:23]) - 150);
  endfunction

  // Reference: exact product in double precision, then rounded to binary32 (RNE, FTZ).
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    bit     xn, xi, xz, yn, yi, yz;
    real    m, scaled, f, rem;
    int     e;
    longint fi;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    xz = (x[30:23] == 8'h00);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    yz = (y[30:23] == 8'h00);
    if (xn || yn) return 32'h7FC00000;
    if ((xi && yz) || (yi && xz)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    m = mag(x) * mag(y);
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    scaled = m * 8388608.0;
    f      = $floor(scaled);
    rem    = scaled - f;
    fi     = longint'(f);
    if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
    if (fi == 64'd16777216) begin fi = 64'd8388608; e++; end
    if (e + 127 >= 255) return {s, 8'hFF, 23'h0};
    if (e + 127 <= 0)   return {s, 31'h0};
    return {s, 8'(e + 127), fi[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          cls;
    logic [31:0] v;
    cls = $urandom_range(0, 15);
    v   = $urandom;
    case (cls)
      0: v[30:0] = 31'h0;
      1: begin v[30:23] = 8'h00; if (v[22:0] == 0) v[0] = 1'b1; end
      2: v[30:0] = {8'hFF, 23'h0};
      3: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      4: v[30:23] = 8'($urandom_range(190, 254));
      5: v[30:23] = 8'($urandom_range(1, 64));
      6: v[30:23] = 8'($urandom_range(1, 254));
      7: begin v[30:23] = 8'($urandom_range(110, 140)); v[19:0] = 20'h0; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    last_exp = expv;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  logic [31:0] da[14] = '{32'h40200000, 32'hBFC00000, 32'h3E800000, 32'h00000000,
                          32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h3F800001,
                          32'h7F7FFFFF, 32'h00800000, 32'h3F800001, 32'h3F800003,
                          32'h3FFFFFFE, 32'h80000000};
  logic [31:0] db[14] = '{32'h40400000, 32'h40800000, 32'h3F000000, 32'h40A00000,
                          32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800001,
                          32'h40000000, 32'h00800000, 32'h3FC00000, 32'h3FC00000,
                          32'h3F800001, 32'hFF800000};
  logic [31:0] dr[14] = '{32'h40F00000, 32'hC0C00000, 32'h3E000000, 32'h00000000,
                          32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3F800002,
                          32'h7F800000, 32'h00000000, 32'h3FC00002, 32'h3FC00004,
                          32'h40000000, 32'h7FC00000};

  initial begin
    logic [31:0] x, y;
    int          guard_cnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    last_exp = '0;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 14; i++) issue(da[i], db[i], dr[i]);
    idle();
    @(posedge clk); #1;
    check("idle_out_valid", {31'b0, out_valid}, 32'h0);
    check("idle_result_held", result, last_exp);
    idle();

    // Random stream with occasional gaps.
    for (int i = 0; i < 600; i++) begin
      x = rand_op();
      y = rand_op();
      issue(x, y, ref_mul(x, y));
      if ($urandom_range(0, 5) == 0) idle();
    end

    // Reset in the middle of a stream discards the in-flight pair.
    issue(32'h3F800000, 32'h40000000, 32'h40000000);
    @(negedge clk);
    a        = 32'h40200000;
    b        = 32'h40400000;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check("midrst_held_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    issue(32'h40200000, 32'h40400000, 32'h40F00000);
    issue(32'hBFC00000, 32'h40800000, 32'hC0C00000);
    idle();

    guard_cnt = 0;
    while (exp_q.size() != 0 && guard_cnt < 20) begin
      @(posedge clk);
      guard_cnt++;
    end
    repeat (2) @(posedge clk);
    #2;
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
